// File: rtl/mul_div_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative multiply/divide unit.
// The pipeline drives the master side; the unit implements the slave side.
interface mul_div_unit_if #(
    parameter int WIDTH = 64
) ();
    logic             valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hold;
    logic             flush;
    logic             stall_mult;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output valid, op, a, b, hold, flush,
        input  stall_mult, done, result
    );

    modport slave (
        input  valid, op, a, b, hold, flush,
        output stall_mult, done, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with RISC-V divide-by-zero results and sign fix-up on completion.
module mul_div_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic         clk,
    input  logic         reset,
    mul_div_unit_if.slave md_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand or dividend
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplier or divisor
    logic [WIDTH-1:0] acc_q, acc_d;   // product or quotient
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    // Decode of the incoming instruction, used only on the start cycle.
    logic             in_div, in_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        in_div    = (md_if.op == OP_DIV) || (md_if.op == OP_DIVU) ||
                    (md_if.op == OP_REM) || (md_if.op == OP_REMU);
        in_signed = (md_if.op == OP_DIV) || (md_if.op == OP_REM);
        a_neg     = in_signed && md_if.a[WIDTH-1];
        b_neg     = in_signed && md_if.b[WIDTH-1];
        a_mag     = a_neg ? -md_if.a : md_if.a;
        b_mag     = b_neg ? -md_if.b : md_if.b;
        b_zero    = (md_if.b == '0);
    end

    // Decode of the latched operation; reserved encodings fall through to MUL.
    logic q_is_div, q_is_rem;

    always_comb begin
        q_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                   (op_q == OP_REM) || (op_q == OP_REMU);
        q_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
    end

    // Restoring-divide step: the shifted partial remainder needs one extra bit
    // for the compare, but after the conditional subtract it always fits WIDTH bits.
    logic [WIDTH:0] rem_shift, rem_sub;
    logic           rem_ge;

    always_comb begin
        rem_shift = {rem_q, opa_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, opb_q};
        rem_sub   = rem_shift - {1'b0, opb_q};
    end

    logic stall_raw, done_raw;

    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        stall_raw = 1'b0;
        done_raw  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (md_if.valid && !md_if.flush) begin
                    stall_raw = 1'b1;
                    op_d      = md_if.op;
                    acc_d     = '0;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (in_div && b_zero) begin
                        // Divide by zero: quotient all ones, remainder is the dividend.
                        opa_d     = md_if.a;
                        opb_d     = md_if.b;
                        acc_d     = '1;
                        rem_d     = md_if.a;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        opa_d     = a_mag;
                        opb_d     = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (q_is_div) begin
                    rem_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    acc_d = {acc_q[WIDTH-2:0], rem_ge};
                    opa_d = opa_q << 1;
                end else begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + opa_q;
                    end
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done_raw = 1'b1;
                if (!md_if.hold) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush aborts whatever is in flight and silences the outputs this cycle.
        if (md_if.flush) begin
            state_d   = S_IDLE;
            stall_raw = 1'b0;
            done_raw  = 1'b0;
        end
    end

    logic [WIDTH-1:0] quo_fixed, rem_fixed;

    always_comb begin
        quo_fixed = neg_quo_q ? -acc_q : acc_q;
        rem_fixed = neg_rem_q ? -rem_q : rem_q;
    end

    // Outputs are also gated by reset so they drop the moment reset asserts,
    // even while a valid instruction is still presented.
    assign md_if.stall_mult = reset && stall_raw;
    assign md_if.done       = reset && done_raw;
    assign md_if.result     = (reset && done_raw) ? (q_is_rem ? rem_fixed : quo_fixed) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the datapath registers are reset too, giving
    // a fully defined state with no dependence on an in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule
